dac_loopback_receiver: RTL

DAC_LOOPBACK_RECEIVER -- requirements
Module: dac_loopback_receiver

---
 rtl/dac_loopback_receiver.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/dac_loopback_receiver.sv
// ---------------------------------------------------------------------------
// dac_loopback_receiver
//
// Purpose:
//   Recovers the I2S frames that the DAC interface transmits by sampling the
//   looped-back BCK/LRCK/DATA pins with the acquisition clock. Two serial
//   lanes carry four 24-bit channels (lane 0: ch0/ch1, lane 1: ch2/ch3).
//   A left word followed by its right word is published as one 128-bit
//   frame together with a single-cycle rx_valid pulse. Short words and
//   right words without a preceding good left word raise a sticky error.
//
// Ports:
//   capture_clk    in   acquisition clock, all logic on its rising edge
//   reset          in   asynchronous, active-high reset
//   enable         in   low holds the receiver in SYNC (rx_buffer held)
//   DAC_BCK        in   looped-back bit clock, data valid on its rise
//   DAC_LRCK       in   looped-back word clock, low = left, high = right
//   DAC_DATA_PINS  in   serial data lanes [0:dac_chips-1]
//   rx_buffer      out  {ch0, ch1, ch2, ch3}, each {24 data bits, 8'h00}
//   rx_valid       out  one-cycle pulse, rx_buffer updated on this cycle
//   frame_error    out  sticky framing error flag
// ---------------------------------------------------------------------------
module dac_loopback_receiver #(
    parameter int dac_chips = 2,
    parameter int data_bits = 24
) (
    input  logic                 capture_clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 DAC_BCK,
    input  logic                 DAC_LRCK,
    input  logic [0:dac_chips-1] DAC_DATA_PINS,
    output logic [127:0]         rx_buffer,
    output logic                 rx_valid,
    output logic                 frame_error
);

    localparam int cnt_w = $clog2(data_bits + 1);
    localparam logic [cnt_w-1:0] full_count = cnt_w'(data_bits);
    localparam logic [cnt_w-1:0] last_count = cnt_w'(data_bits - 1);
    localparam logic [cnt_w-1:0] one_count  = cnt_w'(1);

    typedef enum logic [1:0] {
        SYNC,
        LEFT,
        RIGHT
    } state_t;

    state_t state;
    state_t state_next;

    // Pin synchronisers; only BCK needs the second stage for edge detection.
    logic                 s1_bck;
    logic                 s2_bck;
    logic                 s1_lrck;
    logic [0:dac_chips-1] s1_data;

    logic                 lrck_last;
    logic [cnt_w-1:0]     bit_count;
    logic [data_bits-1:0] shift0;
    logic [data_bits-1:0] shift1;
    logic [data_bits-1:0] ch0;
    logic [data_bits-1:0] ch1;
    logic [data_bits-1:0] ch2;
    logic [data_bits-1:0] ch3;
    logic                 left_ok;
    logic                 word_done;
    logic                 commit_pending;

    logic bck_rise;
    logic boundary;
    logic shift_en;
    logic commit_left;
    logic commit_right;
    logic orphan_right;
    logic short_word;

    assign bck_rise = s1_bck & ~s2_bck;
    // The rise that carries an LRCK change is the I2S dummy bit.
    assign boundary = bck_rise & (s1_lrck != lrck_last);
    assign shift_en = bck_rise & ~boundary & (bit_count < full_count);

    // State register.
    always_ff @(posedge capture_clk or posedge reset) begin
        if (reset) begin
            state <= SYNC;
        end else if (!enable) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: SYNC only leaves on a high-to-low boundary so the
    // first committed word is always a left word.
    always_comb begin
        state_next = state;
        case (state)
            SYNC:    if (boundary && !s1_lrck) state_next = LEFT;
            LEFT:    if (boundary &&  s1_lrck) state_next = RIGHT;
            RIGHT:   if (boundary && !s1_lrck) state_next = LEFT;
            default: state_next = SYNC;
        endcase
    end

    // Output/decision logic. word_done is a registered pulse one cycle after
    // the rise that completed the word; the next boundary rise is at least
    // two cycles later, so the shifters are still stable here.
    always_comb begin
        commit_left  = 1'b0;
        commit_right = 1'b0;
        orphan_right = 1'b0;
        short_word   = 1'b0;
        if (word_done && state == LEFT) begin
            commit_left = 1'b1;
        end
        if (word_done && state == RIGHT) begin
            commit_right = left_ok;
            orphan_right = ~left_ok;
        end
        if (boundary && state != SYNC && bit_count < full_count) begin
            short_word = 1'b1;
        end
    end

    // Datapath: synchronisers, bit counting, shifting, holding registers
    // and the published frame. enable low clears everything except the
    // holding registers and rx_buffer, which keep their contents.
    always_ff @(posedge capture_clk or posedge reset) begin
        if (reset) begin
            s1_bck         <= 1'b0;
            s2_bck         <= 1'b0;
            s1_lrck        <= 1'b0;
            s1_data        <= '0;
            lrck_last      <= 1'b1;
            bit_count      <= '0;
            shift0         <= '0;
            shift1         <= '0;
            ch0            <= '0;
            ch1            <= '0;
            ch2            <= '0;
            ch3            <= '0;
            left_ok        <= 1'b0;
            word_done      <= 1'b0;
            commit_pending <= 1'b0;
            rx_valid       <= 1'b0;
            frame_error    <= 1'b0;
            rx_buffer      <= '0;
        end else if (!enable) begin
            s1_bck         <= 1'b0;
            s2_bck         <= 1'b0;
            s1_lrck        <= 1'b0;
            s1_data        <= '0;
            lrck_last      <= 1'b1;
            bit_count      <= '0;
            shift0         <= '0;
            shift1         <= '0;
            left_ok        <= 1'b0;
            word_done      <= 1'b0;
            commit_pending <= 1'b0;
            rx_valid       <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            s1_bck  <= DAC_BCK;
            s2_bck  <= s1_bck;
            s1_lrck <= DAC_LRCK;
            s1_data <= DAC_DATA_PINS;

            if (bck_rise) begin
                lrck_last <= s1_lrck;
            end

            if (boundary) begin
                bit_count <= '0;
                shift0    <= '0;
                shift1    <= '0;
            end else if (shift_en) begin
                shift0    <= {shift0[data_bits-2:0], s1_data[0]};
                shift1    <= {shift1[data_bits-2:0], s1_data[1]};
                bit_count <= bit_count + one_count;
            end

            word_done <= shift_en && (bit_count == last_count);

            if (commit_left) begin
                ch0     <= shift0;
                ch2     <= shift1;
                left_ok <= 1'b1;
            end
            if (commit_right) begin
                ch1     <= shift0;
                ch3     <= shift1;
                left_ok <= 1'b0;
            end
            if (short_word) begin
                left_ok <= 1'b0;
            end

            commit_pending <= commit_right;
            rx_valid       <= commit_pending;
            frame_error    <= frame_error | short_word | orphan_right;

            if (commit_pending) begin
                rx_buffer <= {ch0, {(32-data_bits){1'b0}},
                              ch1, {(32-data_bits){1'b0}},
                              ch2, {(32-data_bits){1'b0}},
                              ch3, {(32-data_bits){1'b0}}};
            end
        end
    end

endmodule
